// File: rtl/router_ingress_if.sv
// Source/FIFO-side bundle of the router ingress stage.
// The master drives the source byte stream and the FIFO status; the slave is the ingress stage.
interface router_ingress_if;
  logic       pkt_valid;
  logic [7:0] d_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic       busy;
  logic [7:0] d_out;
  logic [2:0] fifo_we;
  logic       lfd;
  logic       err;
  logic       parity_done;

  modport master (
    output pkt_valid, d_in, fifo_full, fifo_empty,
    input  busy, d_out, fifo_we, lfd, err, parity_done
  );

  modport slave (
    input  pkt_valid, d_in, fifo_full, fifo_empty,
    output busy, d_out, fifo_we, lfd, err, parity_done
  );
endinterface

// File: rtl/router_ingress.sv
// Ingress stage of the 1-to-3 router: decodes the header, streams the packet through a
// one-byte hold register into the selected FIFO, and checks the trailing parity byte.
module router_ingress (
  input  logic clk,
  input  logic rst,
  router_ingress_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT, ARM, LOAD, CHECK, DROP} state_t;

  state_t     state, state_nx;
  logic [7:0] hold, acc, rx_par;
  logic       hold_valid;
  logic [5:0] rem;
  logic [1:0] addr;
  logic       err_r;

  logic [2:0] sel;
  logic       tgt_full, tgt_empty, hdr_empty;
  logic       busy, wr, accept, lfd, pd, err_chk, par_byte;

  // Shifting by address 3 yields an all-zero select, so the invalid address hits no FIFO.
  assign sel       = 3'b001 << addr;
  assign tgt_full  = |(bus.fifo_full & sel);
  assign tgt_empty = |(bus.fifo_empty & sel);
  assign hdr_empty = |(bus.fifo_empty & (3'b001 << bus.d_in[1:0]));
  assign par_byte  = (rem == 6'd0);

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    wr       = 1'b0;
    accept   = 1'b0;
    lfd      = 1'b0;
    pd       = 1'b0;
    err_chk  = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.pkt_valid;
        if (accept)
          state_nx = (bus.d_in[1:0] == 2'd3) ? DROP : (hdr_empty ? ARM : WAIT);
      end
      WAIT: begin
        busy = 1'b1;
        if (tgt_empty) state_nx = ARM;
      end
      ARM: begin
        busy     = 1'b1;
        lfd      = 1'b1;
        state_nx = LOAD;
      end
      LOAD: begin
        busy   = hold_valid & tgt_full;
        wr     = hold_valid & ~tgt_full;
        accept = ~busy & (par_byte | bus.pkt_valid);
        if (accept && par_byte) state_nx = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        wr   = hold_valid & ~tgt_full;
        if (!hold_valid) begin
          pd       = 1'b1;
          err_chk  = (acc != rx_par);
          state_nx = IDLE;
        end
      end
      DROP: begin
        accept = par_byte | bus.pkt_valid;
        if (accept && par_byte) begin
          pd       = 1'b1;
          err_chk  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= 8'h00;
      hold_valid <= 1'b0;
      acc        <= 8'h00;
      rx_par     <= 8'h00;
      rem        <= 6'd0;
      addr       <= 2'd0;
      err_r      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          hold       <= bus.d_in;
          hold_valid <= (bus.d_in[1:0] != 2'd3);
          acc        <= bus.d_in;
          rem        <= bus.d_in[7:2];
          addr       <= bus.d_in[1:0];
          err_r      <= 1'b0;
        end
        LOAD: begin
          if (accept) begin
            hold       <= bus.d_in;
            hold_valid <= 1'b1;
            if (par_byte) begin
              rx_par <= bus.d_in;
              // Still flagged valid on the parity slot: payload longer than the header said.
              if (bus.pkt_valid) err_r <= 1'b1;
            end else begin
              acc <= acc ^ bus.d_in;
              rem <= rem - 6'd1;
            end
          end else if (wr) begin
            hold_valid <= 1'b0;
          end
        end
        CHECK: begin
          if (wr) hold_valid <= 1'b0;
          if (pd) err_r <= err_r | err_chk;
        end
        DROP: if (accept) begin
          if (par_byte) err_r <= 1'b1;
          else          rem   <= rem - 6'd1;
        end
        default: ;
      endcase
    end
  end

  // err is combined with the completing cycle's verdict so it is valid during parity_done.
  assign bus.busy        = busy;
  assign bus.d_out       = hold;
  assign bus.fifo_we     = wr ? sel : 3'b000;
  assign bus.lfd         = lfd;
  assign bus.err         = err_r | err_chk;
  assign bus.parity_done = pd;
endmodule

// File: tb/tb_router_ingress.sv
// Directed bench for router_ingress: FIFO writes, lfd, busy and parity/err behaviour.
module tb_router_ingress;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_ingress_if bus_if();
  router_ingress dut (.clk(clk), .rst(rst), .bus(bus_if));

  int checks = 0;
  int errors = 0;

  logic [2:0] wq_we[$];
  logic [7:0] wq_d[$];
  int         wq_c[$];
  int         cyc = 0, nlfd = 0, lfd_cyc = 0, npd = 0, viol = 0;
  logic       err_pd = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.fifo_we != 3'b000) begin
        wq_we.push_back(bus_if.fifo_we);
        wq_d.push_back(bus_if.d_out);
        wq_c.push_back(cyc);
      end
      if (bus_if.lfd) begin nlfd++; lfd_cyc = cyc; end
      if (bus_if.parity_done) begin npd++; err_pd = bus_if.err; end
      if ((bus_if.fifo_we & bus_if.fifo_full) != 3'b000) viol++;
    end
    cyc++;
  end

  task automatic clear_logs();
    wq_we.delete(); wq_d.delete(); wq_c.delete();
    nlfd = 0; npd = 0; viol = 0; err_pd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pv);
    bus_if.d_in = b;
    bus_if.pkt_valid = pv;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus_if.busy) begin
        @(posedge clk); #1;
        bus_if.pkt_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL send_byte: byte %h not accepted within 200 cycles", b);
    bus_if.pkt_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b[$], input logic [7:0] par);
    foreach (b[i]) send_byte(b[i], 1'b1);
    send_byte(par, 1'b0);
  endtask

  task automatic wait_pd(input int target);
    for (int i = 0; i < 200; i++) begin
      if (npd >= target) break;
      @(posedge clk);
    end
    #1;
    checks++;
    if (npd < target) begin
      errors++;
      $display("FAIL wait_pd: parity_done count %0d, required %0d", npd, target);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin
      bus_if.d_in = 8'($urandom); bus_if.pkt_valid = 1'($urandom);
      bus_if.fifo_full = 3'($urandom); bus_if.fifo_empty = 3'($urandom);
      @(negedge clk);
      checks += 5;
      if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
      if (bus_if.fifo_we !== 3'b000) begin errors++; $display("FAIL reset_we: got %b want 000", bus_if.fifo_we); end
      if (bus_if.lfd !== 1'b0) begin errors++; $display("FAIL reset_lfd: got %b want 0", bus_if.lfd); end
      if (bus_if.d_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus_if.d_out); end
      if (bus_if.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_if.err); end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus_if.d_in = 8'h00; bus_if.pkt_valid = 1'b0;
    bus_if.fifo_full = 3'b000; bus_if.fifo_empty = 3'b111;
    @(posedge clk); #1;
  endtask

  task automatic test_good(input logic [7:0] par, input logic exp_err, input string nm);
    logic [7:0] pk[$];
    logic [7:0] exp[$];
    pk = '{8'h0D, 8'h11, 8'h22, 8'h33};
    exp = '{8'h0D, 8'h11, 8'h22, 8'h33, par};
    clear_logs();
    send_pkt(pk, par);
    wait_pd(1);
    checks++;
    if (wq_d.size() != 5) begin errors++; $display("FAIL %s_count: got %0d writes want 5", nm, wq_d.size()); end
    for (int i = 0; i < 5 && i < wq_d.size(); i++) begin
      checks += 3;
      if (wq_we[i] !== 3'b010) begin errors++; $display("FAIL %s_we[%0d]: got %b want 010", nm, i, wq_we[i]); end
      if (wq_d[i] !== exp[i]) begin errors++; $display("FAIL %s_data[%0d]: got %h want %h", nm, i, wq_d[i], exp[i]); end
      if (wq_c[i] != wq_c[0] + i) begin errors++; $display("FAIL %s_consec[%0d]: cycle %0d want %0d", nm, i, wq_c[i], wq_c[0] + i); end
    end
    checks += 4;
    if (nlfd != 1) begin errors++; $display("FAIL %s_lfd_count: got %0d want 1", nm, nlfd); end
    if (wq_c.size() > 0 && lfd_cyc + 1 != wq_c[0]) begin errors++; $display("FAIL %s_lfd_pos: lfd cycle %0d first write %0d", nm, lfd_cyc, wq_c[0]); end
    if (npd != 1) begin errors++; $display("FAIL %s_pd_count: got %0d want 1", nm, npd); end
    if (err_pd !== exp_err) begin errors++; $display("FAIL %s_err: got %b want %b", nm, err_pd, exp_err); end
  endtask

  task automatic test_full_stall();
    logic [7:0] pk[$];
    logic [7:0] exp[$];
    pk = '{8'h10, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp = '{8'h10, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h14};
    clear_logs();
    fork
      send_pkt(pk, 8'h14);
      begin
        int i;
        for (i = 0; i < 300; i++) begin
          @(posedge clk);
          if (wq_d.size() >= 3) break;
        end
        #1;
        bus_if.fifo_full = 3'b001;
        repeat (3) begin
          @(negedge clk);
          checks += 2;
          if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", bus_if.busy); end
          if (bus_if.fifo_we[0] !== 1'b0) begin errors++; $display("FAIL stall_we: got %b want 0", bus_if.fifo_we[0]); end
        end
        @(posedge clk); #1;
        bus_if.fifo_full = 3'b000;
        @(negedge clk);
        checks++;
        if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL stall_release: busy %b want 0", bus_if.busy); end
      end
    join
    wait_pd(1);
    checks += 3;
    if (wq_d.size() != 6) begin errors++; $display("FAIL stall_count: got %0d writes want 6", wq_d.size()); end
    if (viol != 0) begin errors++; $display("FAIL stall_we_while_full: got %0d want 0", viol); end
    if (err_pd !== 1'b0) begin errors++; $display("FAIL stall_err: got %b want 0", err_pd); end
    for (int i = 0; i < 6 && i < wq_d.size(); i++) begin
      checks += 2;
      if (wq_we[i] !== 3'b001) begin errors++; $display("FAIL stall_we[%0d]: got %b want 001", i, wq_we[i]); end
      if (wq_d[i] !== exp[i]) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", i, wq_d[i], exp[i]); end
    end
  endtask

  task automatic test_wait_empty();
    logic [7:0] exp[$];
    exp = '{8'h0A, 8'h01, 8'h02, 8'h09};
    clear_logs();
    bus_if.fifo_empty = 3'b011;
    bus_if.d_in = 8'h0A; bus_if.pkt_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL wait_idle_busy: got %b want 0", bus_if.busy); end
    @(posedge clk); #1;
    bus_if.d_in = 8'h01;
    repeat (3) begin
      @(negedge clk);
      checks += 3;
      if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b want 1", bus_if.busy); end
      if (bus_if.lfd !== 1'b0) begin errors++; $display("FAIL wait_lfd: got %b want 0", bus_if.lfd); end
      if (bus_if.fifo_we !== 3'b000) begin errors++; $display("FAIL wait_we: got %b want 000", bus_if.fifo_we); end
    end
    @(posedge clk); #1;
    bus_if.fifo_empty = 3'b111;
    @(negedge clk);
    checks += 2;
    if (bus_if.lfd !== 1'b0) begin errors++; $display("FAIL wait_rise_lfd: got %b want 0", bus_if.lfd); end
    if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL wait_rise_busy: got %b want 1", bus_if.busy); end
    @(negedge clk);
    checks++;
    if (bus_if.lfd !== 1'b1) begin errors++; $display("FAIL wait_lfd_pulse: got %b want 1", bus_if.lfd); end
    @(posedge clk); #1;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h09, 1'b0);
    wait_pd(1);
    checks += 3;
    if (wq_d.size() != 4) begin errors++; $display("FAIL wait_count: got %0d writes want 4", wq_d.size()); end
    if (nlfd != 1) begin errors++; $display("FAIL wait_lfd_count: got %0d want 1", nlfd); end
    if (err_pd !== 1'b0) begin errors++; $display("FAIL wait_err: got %b want 0", err_pd); end
    for (int i = 0; i < 4 && i < wq_d.size(); i++) begin
      checks += 2;
      if (wq_we[i] !== 3'b100) begin errors++; $display("FAIL wait_we[%0d]: got %b want 100", i, wq_we[i]); end
      if (wq_d[i] !== exp[i]) begin errors++; $display("FAIL wait_data[%0d]: got %h want %h", i, wq_d[i], exp[i]); end
    end
  endtask

  task automatic test_invalid_and_reset();
    logic [7:0] pk[$];
    pk = '{8'h07, 8'h55};
    clear_logs();
    send_pkt(pk, 8'h52);
    wait_pd(1);
    checks += 4;
    if (wq_d.size() != 0) begin errors++; $display("FAIL drop_writes: got %0d want 0", wq_d.size()); end
    if (npd != 1) begin errors++; $display("FAIL drop_pd: got %0d want 1", npd); end
    if (err_pd !== 1'b1) begin errors++; $display("FAIL drop_err: got %b want 1", err_pd); end
    if (nlfd != 0) begin errors++; $display("FAIL drop_lfd: got %0d want 0", nlfd); end

    clear_logs();
    send_byte(8'h09, 1'b1);
    send_byte(8'h01, 1'b1);
    checks++;
    if (wq_d.size() != 1 || (wq_d.size() == 1 && wq_d[0] !== 8'h09)) begin
      errors++; $display("FAIL midrst_hdr: got %0d writes want 1 (09)", wq_d.size());
    end
    rst = 1'b1;
    bus_if.d_in = 8'h02; bus_if.pkt_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.pkt_valid = 1'b0;
    clear_logs();
    @(negedge clk);
    checks += 3;
    if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus_if.busy); end
    if (bus_if.d_out !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h want 00", bus_if.d_out); end
    if (bus_if.fifo_we !== 3'b000) begin errors++; $display("FAIL midrst_we: got %b want 000", bus_if.fifo_we); end
    repeat (6) @(posedge clk);
    #1;
    checks += 2;
    if (wq_d.size() != 0) begin errors++; $display("FAIL midrst_writes: got %0d want 0", wq_d.size()); end
    if (npd != 0) begin errors++; $display("FAIL midrst_pd: got %0d want 0", npd); end
  endtask

  initial begin
    bus_if.d_in = 8'h00; bus_if.pkt_valid = 1'b0;
    bus_if.fifo_full = 3'b000; bus_if.fifo_empty = 3'b111;
    test_reset();
    test_good(8'h0D, 1'b0, "good");
    test_good(8'h0E, 1'b1, "badpar");
    test_full_stall();
    test_wait_empty();
    test_invalid_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_ingress.md
# router_ingress

Ingress stage of the 1-to-3 packet router. It sits directly upstream of the three `router_fifo` instances. It accepts a byte-serial packet from the source, decodes the destination from the header, and writes header, payload and parity into the selected FIFO. It drives the FIFO's `lfd` marker, applies back-pressure to the source through `busy`, and checks packet parity.

## Interface
No parameters (data width 8, three destinations; both fixed).
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pkt_valid` input 1: source marks header/payload bytes; low on the parity byte.
- `d_in` input 8: source byte.
- `fifo_full` input 3: per-FIFO full, bit k = FIFO k.
- `fifo_empty` input 3: per-FIFO empty.
- `busy` output 1: source must hold `d_in`/`pkt_valid` while high.
- `d_out` output 8: byte to FIFOs (common bus), driven from the hold register.
- `fifo_we` output 3: write enable, at most one bit high.
- `lfd` output 1: header marker; FIFO delays it one cycle internally.
- `err` output 1: parity or address error of the last packet; held until the next header is accepted.
- `parity_done` output 1: one-cycle pulse at packet completion.

## Operation
- Packet format:
  - header `[7:2]` = payload length L (0..63), `[1:0]` = address (0..2 valid, 3 invalid);
  - then L payload bytes with `pkt_valid`=1;
  - then one parity byte with `pkt_valid`=0.
  - Parity = XOR of header and all payload bytes.
- Datapath:
  - one-byte hold register plus `hold_valid`, 6-bit remaining counter `rem`, 8-bit `acc` (running XOR), 8-bit `rx_par`, 2-bit `addr`.
  - `d_out` = hold register.
- Accept condition: a byte is accepted at an edge where `busy`=0 and the state expects a byte.
- Write rule: `fifo_we[addr]` = `hold_valid` & !`fifo_full[addr]`, combinational, only in LOAD and CHECK.
- Same-edge write and accept: the hold register reloads.
- Write only: `hold_valid` clears.
- States:
  - **IDLE** (`busy`=0): on `pkt_valid`=1, accept header into hold and set `hold_valid`=1, `acc`=`d_in`, `rem`=`d_in[7:2]`, `addr`=`d_in[1:0]`, `err`=0.
    - `addr`==3 → DROP.
    - else `fifo_empty[addr]` → ARM.
    - else → WAIT.
  - **WAIT** (`busy`=1): stay until `fifo_empty[addr]`=1, then → ARM.
  - **ARM** (`busy`=1, `lfd`=1 for exactly this cycle): → LOAD.
  - **LOAD** (`busy` = `hold_valid` & `fifo_full[addr]`):
    - If `rem`>0, accept only when `pkt_valid`=1; a low `pkt_valid` is a gap, nothing accepted. On accept: `acc` ^= byte, `rem`−1.
    - If `rem`==0, accept the next byte as parity into hold and `rx_par`. If `pkt_valid`=1 on that byte, set `err`=1 (length mismatch). → CHECK.
  - **CHECK** (`busy`=1): write hold when not full. When `hold_valid`=0 at cycle start: `err` |= (`acc`!=`rx_par`), `parity_done`=1, → IDLE.
  - **DROP** (`busy`=0, no writes): consume L payload bytes plus parity by the same rules. On the parity accept: `err`=1, `parity_done`=1, → IDLE.
- Header write: the header is written in the first LOAD cycle. The FIFO is empty at that point, so its internal lfd bit tags only the header.
- Zero length (L=0): the byte after the header is parity.

## Timing
- Reset (`rst`=1 at edge):
  - state IDLE, `hold_valid`=0, hold=0, `rem`=0, `acc`=0, `rx_par`=0;
  - outputs: `busy`=0, `d_out`=0x00, `fifo_we`=000, `lfd`=0, `err`=0, `parity_done`=0;
  - reset overrides every other event.
- Reset mid-packet: the partial packet is abandoned, with no further writes and no `parity_done`.
- Latency:
  - header accepted at edge E;
  - ARM cycle E..E+1 with `lfd`=1;
  - header written at E+2, while payload byte 1 is accepted at E+2.
  - Steady state: one byte per cycle.
- Back-pressure:
  - `busy` depends combinationally on `fifo_full`;
  - `fifo_we` is never high while the target `fifo_full` is high;
  - no byte is lost or duplicated.
- `parity_done` is high for exactly one cycle. `err` is valid from that cycle until the next header accept.
- A new header cannot be accepted in the `parity_done` cycle; the earliest next header accept is the following edge (IDLE).

## Test plan
- Reset: hold `rst`=1 for 2 cycles with random inputs → `busy`=0, `fifo_we`=000, `lfd`=0, `d_out`=0x00, `err`=0.
- Good packet: header 0x0D (L=3, addr 1), payload 0x11 0x22 0x33, parity 0x0D, all FIFOs empty/not full → `lfd` high 1 cycle, then `fifo_we`=010 for 5 consecutive cycles carrying 0D,11,22,33,0D; `parity_done` pulse; `err`=0.
- Bad parity: same packet with parity 0x0E → identical writes; `err`=1 at `parity_done`.
- Full stall: packet to addr 0, L=4; `fifo_full[0]`=1 for 3 cycles after the second payload write → `busy`=1 exactly during the stall, `fifo_we[0]`=0 during it; all 6 bytes arrive in order.
- Wait for empty: `fifo_empty[2]`=0 when header 0x0A (L=2, addr 2) is accepted → `busy`=1 and `lfd`=0 until `fifo_empty[2]` rises; `lfd` pulses the cycle after the rise.
- Invalid address: header 0x07 (L=1, addr 3), payload 0x55, parity 0x52 → `fifo_we`=000 throughout; `err`=1 with `parity_done`. Then assert `rst` mid-way through a following addr-1 packet → no further writes; IDLE after reset.
